// File: rtl/dca_matrix_lsu_row_unpacker_pkg.sv
// dca_matrix_lsu_row_unpacker_pkg: shared LSU widths, element width codes and output-stage states.
package dca_matrix_lsu_row_unpacker_pkg;
  localparam logic [2:0] DCA_ELEM_W1 = 3'd0;
  localparam logic [2:0] DCA_ELEM_W2 = 3'd1;
  localparam logic [2:0] DCA_ELEM_W4 = 3'd2;
  localparam logic [2:0] DCA_ELEM_W8 = 3'd3;
  localparam logic [2:0] DCA_ELEM_W16 = 3'd4;
  localparam logic [2:0] DCA_ELEM_W32 = 3'd5;
  localparam int BW_DCA_MATRIX_INFO_NUM_ROW_M1 = 8;
  function automatic int lsu_elem_bw(int lsu_para);
    return lsu_para == 1 ? 64 : 32;
  endfunction
  function automatic int txn_info_bw(int lsu_para);
    return lsu_para == 1 ? 16 : 8;
  endfunction
  function automatic int num_col(int matrix_size_para);
    return matrix_size_para;
  endfunction
  function automatic int row_buf_bw(int axi_para, int matrix_size_para);
    return axi_para * num_col(matrix_size_para);
  endfunction
  localparam int BW_LSU_ELEMENT = lsu_elem_bw(0);
  localparam int MATRIX_NUM_COL = num_col(4);
  localparam int BW_MEMORY_ROW_BUFFER = row_buf_bw(32, 4);
  localparam int BW_TXN_INFO = txn_info_bw(0);
  function automatic logic [5:0] width_of(logic [2:0] code);
    return code >= DCA_ELEM_W32 ? 6'd32 : 6'(6'd1 << code);
  endfunction
  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL
`ifdef DCA_ROW_UNPACK_SKID_EN
    , ST_SKID
`endif
  } state_t;
endpackage

// File: rtl/dca_matrix_lsu_row_unpacker_if.sv
// dca_matrix_lsu_row_unpacker_if: valid/ready row bus with transaction info.
interface dca_matrix_lsu_row_unpacker_if #(parameter int BW_ROW = 128, parameter int BW_INFO = 8) ();
  logic valid;
  logic ready;
  logic [BW_ROW-1:0] row;
  logic [BW_INFO-1:0] info;
  modport master(output valid, row, info, input ready);
  modport slave(input valid, row, info, output ready);
endinterface

// File: rtl/dca_lsu_elem_extend.sv
// dca_lsu_elem_extend: extracts lane LANE of a packed row and sign/zero-extends it to BW_ELEM bits.
module dca_lsu_elem_extend
  import dca_matrix_lsu_row_unpacker_pkg::*;
#(
  parameter int LANE = 0,
  parameter int BW_ROW = 128,
  parameter int BW_ELEM = 32
) (
  input  logic [BW_ROW-1:0]  row,
  input  logic [2:0]         code,
  input  logic               is_signed,
  output logic [BW_ELEM-1:0] elem
);
  logic [5:0] w;
  logic [BW_ELEM-1:0] sh;
  logic [BW_ELEM-1:0] m;
  logic neg;
  always_comb begin
    w = width_of(code);
    sh = BW_ELEM'(row >> (w * LANE));
    m = (32'(w) >= BW_ELEM) ? '1 : ~({BW_ELEM{1'b1}} << w);
    neg = is_signed && code != DCA_ELEM_W1 && sh[w-6'd1];
    elem = (sh & m) | (neg ? ~m : '0);
  end
endmodule

// File: rtl/dca_matrix_lsu_row_unpacker.sv
// dca_matrix_lsu_row_unpacker: unpacks narrow packed elements into LSU lanes behind a registered valid/ready stage.
// Defining DCA_ROW_UNPACK_SKID_EN adds a one-entry skid so in_ready no longer depends on out_ready.
module dca_matrix_lsu_row_unpacker
  import dca_matrix_lsu_row_unpacker_pkg::*;
#(
  parameter int LSU_PARA = 0,
  parameter int AXI_PARA = 32,
  parameter int MATRIX_SIZE_PARA = 4,
  localparam int E = lsu_elem_bw(LSU_PARA),
  localparam int NCOL = num_col(MATRIX_SIZE_PARA),
  localparam int ROW = row_buf_bw(AXI_PARA, MATRIX_SIZE_PARA),
  localparam int INFO = txn_info_bw(LSU_PARA)
) (
  input  logic clk,
  input  logic rstnn,
  input  logic clear,
  input  logic [2:0] cfg_width_code,
  input  logic cfg_is_signed,
  input  logic [BW_DCA_MATRIX_INFO_NUM_ROW_M1-1:0] cfg_num_row_m1,
  input  logic [NCOL-1:0] cfg_col_mask,
  dca_matrix_lsu_row_unpacker_if.slave in_if,
  dca_matrix_lsu_row_unpacker_if.master out_if,
  output logic out_last
);
  localparam int BW_BEAT = E * NCOL + INFO + 1;
  state_t state, state_n;
  logic live, acc, drn, last_d, load_out;
  logic [BW_DCA_MATRIX_INFO_NUM_ROW_M1-1:0] row_cnt;
  logic [E*NCOL-1:0] unpacked;
  logic [BW_BEAT-1:0] nb, ob;
  for (genvar i = 0; i < NCOL; i++) begin : g_lane
    logic [E-1:0] e;
    dca_lsu_elem_extend #(.LANE(i), .BW_ROW(ROW), .BW_ELEM(E)) u_ext (
      .row(in_if.row), .code(cfg_width_code), .is_signed(cfg_is_signed), .elem(e)
    );
    assign unpacked[i*E +: E] = cfg_col_mask[i] ? e : '0;
  end
  assign last_d = row_cnt == cfg_num_row_m1;
  assign nb = {unpacked, in_if.info, last_d};
  assign {out_if.row, out_if.info, out_last} = ob;
  assign out_if.valid = state != ST_EMPTY;
  assign acc = in_if.valid && in_if.ready;
  assign drn = out_if.valid && out_if.ready;
`ifdef DCA_ROW_UNPACK_SKID_EN
  logic [BW_BEAT-1:0] sb;
  logic load_skid;
  assign in_if.ready = live && !clear && state != ST_SKID;
  always_comb begin
    state_n = state;
    load_out = 1'b0;
    load_skid = 1'b0;
    if (clear) state_n = ST_EMPTY;
    else case (state)
      ST_EMPTY: begin
        state_n = acc ? ST_FULL : ST_EMPTY;
        load_out = acc;
      end
      ST_FULL: begin
        state_n = acc ? (drn ? ST_FULL : ST_SKID) : (drn ? ST_EMPTY : ST_FULL);
        load_out = acc && drn;
        load_skid = acc && !drn;
      end
      ST_SKID: state_n = drn ? ST_FULL : ST_SKID;
      default: state_n = ST_EMPTY;
    endcase
  end
`else
  assign in_if.ready = live && !clear && (state == ST_EMPTY || out_if.ready);
  always_comb begin
    state_n = state;
    load_out = 1'b0;
    if (clear) state_n = ST_EMPTY;
    else case (state)
      ST_EMPTY: begin
        state_n = acc ? ST_FULL : ST_EMPTY;
        load_out = acc;
      end
      ST_FULL: begin
        state_n = (drn && !acc) ? ST_EMPTY : ST_FULL;
        load_out = acc;
      end
      default: state_n = ST_EMPTY;
    endcase
  end
`endif
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      state <= ST_EMPTY;
      live <= 1'b0;
      row_cnt <= '0;
      ob <= '0;
`ifdef DCA_ROW_UNPACK_SKID_EN
      sb <= '0;
`endif
    end else begin
      state <= state_n;
      live <= 1'b1;
      if (clear) row_cnt <= '0;
      else if (acc) row_cnt <= last_d ? '0 : row_cnt + 1'b1;
      if (load_out) ob <= nb;
`ifdef DCA_ROW_UNPACK_SKID_EN
      else if (state == ST_SKID && drn) ob <= sb;
      if (load_skid) sb <= nb;
`endif
    end
  end
endmodule

// File: tb/tb_dca_matrix_lsu_row_unpacker.sv
// tb_dca_matrix_lsu_row_unpacker: directed and randomized checks against a queue-based reference model.
module tb_dca_matrix_lsu_row_unpacker;
  import dca_matrix_lsu_row_unpacker_pkg::*;
`ifdef DCA_ROW_UNPACK_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  typedef struct {
    logic [127:0] row;
    logic [7:0] info;
    logic last;
  } beat_t;
  logic clk = 1'b0;
  logic rstnn, clear, cfg_is_signed, out_last;
  logic [2:0] cfg_width_code;
  logic [7:0] cfg_num_row_m1;
  logic [3:0] cfg_col_mask;
  int checks = 0;
  int failures = 0;
  int nlast = 0;
  logic [7:0] mcnt;
  beat_t q[$];
  logic [127:0] r;
  dca_matrix_lsu_row_unpacker_if #(.BW_ROW(BW_MEMORY_ROW_BUFFER), .BW_INFO(BW_TXN_INFO)) in_if ();
  dca_matrix_lsu_row_unpacker_if #(.BW_ROW(BW_LSU_ELEMENT * MATRIX_NUM_COL), .BW_INFO(BW_TXN_INFO)) out_if ();
  dca_matrix_lsu_row_unpacker dut (
    .clk(clk), .rstnn(rstnn), .clear(clear), .cfg_width_code(cfg_width_code),
    .cfg_is_signed(cfg_is_signed), .cfg_num_row_m1(cfg_num_row_m1), .cfg_col_mask(cfg_col_mask),
    .in_if(in_if), .out_if(out_if), .out_last(out_last)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] ref_lane(logic [127:0] row, int code, bit sgn, int i);
    int w;
    longint v;
    w = code >= 5 ? 32 : 1 << code;
    v = 0;
    for (int b = 0; b < w; b++) if (row[w*i+b]) v += longint'(1) << b;
    if (sgn && code != 0 && v >= (longint'(1) << (w - 1))) v -= longint'(1) << w;
    return v[31:0];
  endfunction
  function automatic logic [127:0] ref_row(logic [127:0] row, int code, bit sgn, logic [3:0] mask);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 4; i++) if (mask[i]) o[i*32 +: 32] = ref_lane(row, code, sgn, i);
    return o;
  endfunction
  task automatic drive(bit v, bit ordy, logic [127:0] row);
    in_if.valid = v;
    in_if.row = row;
    in_if.info = 8'($urandom);
    out_if.ready = ordy;
  endtask
  task automatic tick();
    bit exp_rdy, acc, drn;
    beat_t b;
    #1;
    exp_rdy = !clear && (SKID ? q.size() < 2 : (q.size() == 0 || out_if.ready));
    chk("in_ready", 128'(in_if.ready), 128'(exp_rdy));
    acc = in_if.valid && exp_rdy;
    drn = q.size() > 0 && out_if.ready;
    b.row = ref_row(in_if.row, int'(cfg_width_code), cfg_is_signed, cfg_col_mask);
    b.info = in_if.info;
    b.last = mcnt == cfg_num_row_m1;
    @(posedge clk);
    if (clear) begin
      q.delete();
      mcnt = '0;
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(b);
        mcnt = b.last ? 8'd0 : mcnt + 8'd1;
      end
    end
    @(negedge clk);
    chk("out_valid", 128'(out_if.valid), 128'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_row", out_if.row, q[0].row);
      chk("out_info", 128'(out_if.info), 128'(q[0].info));
      chk("out_last", 128'(out_last), 128'(q[0].last));
      if (out_if.valid && out_last && out_if.ready) nlast++;
    end
  endtask
  initial begin
    rstnn = 1'b0;
    clear = 1'b0;
    mcnt = '0;
    cfg_width_code = 3'd3;
    cfg_is_signed = 1'b1;
    cfg_num_row_m1 = 8'd2;
    cfg_col_mask = 4'hf;
    drive(1'b1, 1'b1, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(out_if.valid), 128'd0);
    chk("rst_out_last", 128'(out_last), 128'd0);
    chk("rst_out_row", out_if.row, 128'd0);
    chk("rst_out_info", 128'(out_if.info), 128'd0);
    chk("rst_in_ready", 128'(in_if.ready), 128'd0);
    rstnn = 1'b1;
    drive(1'b0, 1'b1, '0);
    @(negedge clk);
    drive(1'b1, 1'b1, 128'h7f80);
    tick();
    chk("s8_lane0", 128'(out_if.row[31:0]), 128'hffffff80);
    chk("s8_lane1", 128'(out_if.row[63:32]), 128'h7f);
    cfg_width_code = 3'd0;
    r = {124'($urandom), 4'b1010};
    drive(1'b1, 1'b1, r);
    tick();
    chk("b1_lanes", out_if.row, {32'd1, 32'd0, 32'd1, 32'd0});
    cfg_width_code = 3'd6;
    cfg_col_mask = 4'b0101;
    r = {$urandom, $urandom, $urandom, $urandom};
    drive(1'b1, 1'b1, r);
    tick();
    chk("w32_lane0", 128'(out_if.row[31:0]), 128'(r[31:0]));
    chk("w32_lane2", 128'(out_if.row[95:64]), 128'(r[95:64]));
    chk("w32_masked", 128'({out_if.row[127:96], out_if.row[63:32]}), 128'd0);
    drive(1'b0, 1'b1, '0);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    cfg_width_code = 3'd3;
    cfg_col_mask = 4'hf;
    nlast = 0;
    repeat (7) begin
      drive(1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom});
      tick();
    end
    chk("last_count", 128'(nlast), 128'd2);
    drive(1'b0, 1'b1, '0);
    tick();
    repeat (3) begin
      drive(1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom});
      tick();
    end
    chk("bp_in_ready", 128'(in_if.ready), 128'd0);
    repeat (4) begin
      drive(1'b0, 1'b1, '0);
      tick();
    end
    repeat (2) begin
      drive(1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom});
      tick();
    end
    clear = 1'b1;
    drive(1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom});
    tick();
    clear = 1'b0;
    chk("clear_out_valid", 128'(out_if.valid), 128'd0);
    drive(1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom});
    tick();
    chk("clear_next_last", 128'(out_last), 128'd0);
    drive(1'b0, 1'b1, '0);
    tick();
    for (int blk = 0; blk < 8; blk++) begin
      cfg_width_code = 3'($urandom_range(0, 7));
      cfg_is_signed = 1'($urandom_range(0, 1));
      cfg_col_mask = 4'($urandom_range(0, 15));
      cfg_num_row_m1 = 8'($urandom_range(0, 3));
      repeat (40) begin
        clear = $urandom_range(0, 19) == 0;
        drive(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom, $urandom});
        tick();
      end
      clear = 1'b0;
      drive(1'b0, 1'b1, '0);
      repeat (3) tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
